univ_shift_reg: RTL

- Parametrised universal shift register; successor to the fixed 4-bit load/serial-in shift register.
- Adds configurable width, six shift/rotate modes, dual serial inputs and outputs, and a counted burst-shift engine with busy/done handshake.
- Used as the datapath element for serialisers, bit-banged links and test pattern generators.

---
 rtl/shreg_pkg.sv | 19 +
 rtl/univ_shift_reg_if.sv | 46 ++++
 rtl/shreg_next.sv | 26 ++
 rtl/univ_shift_reg.sv | 110 +++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register: shift modes and burst FSM states.
package shreg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_ASR  = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg.
// Build option: SHREG_PARITY_EN adds the registered parity output par_out.
interface univ_shift_reg_if
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  // Handshake: start is taken only while idle (busy=0, done=0); busy is then high for exactly
  // count cycles, one shift each, followed by a single-cycle done pulse with busy low.
  logic             load;
  logic [WIDTH-1:0] par_in;
  mode_t            mode;
  logic             step;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
  state_t           state;
`ifdef SHREG_PARITY_EN
  logic             par_out;
`endif

  modport master (
    output load, par_in, mode, step, start, count, sin_l, sin_r,
`ifdef SHREG_PARITY_EN
    input  par_out,
`endif
    input  q, sout_l, sout_r, busy, done, state
  );

  modport slave (
    input  load, par_in, mode, step, start, count, sin_l, sin_r,
`ifdef SHREG_PARITY_EN
    output par_out,
`endif
    output q, sout_l, sout_r, busy, done, state
  );

endinterface

// File: rtl/shreg_next.sv
// Combinational next-value function for one shift of the register in the given mode.
module shreg_next
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] q,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL: q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR: q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ASR: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_ROL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: q_next = {q[0], q[WIDTH-1:1]};
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single step and counted burst shifting.
// Build option: define SHREG_PARITY_EN to add registered parity output par_out.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  univ_shift_reg_if.slave bus
);

  state_t           state, state_d;
  logic [CNT_W-1:0] remaining, rem_d;
  mode_t            mode_l, mode_d;
  logic [WIDTH-1:0] q_r, q_d;
  logic             busy_r, busy_d;
  logic             done_r, done_d;
  mode_t            shift_mode;
  logic [WIDTH-1:0] shift_q;

  // Bursts use the mode captured at start; single steps use the live mode.
  assign shift_mode = (state == ST_SHIFT) ? mode_l : bus.mode;

  shreg_next #(.WIDTH(WIDTH)) u_next (
    .mode   (shift_mode),
    .q      (q_r),
    .sin_l  (bus.sin_l),
    .sin_r  (bus.sin_r),
    .q_next (shift_q)
  );

  always_comb begin
    state_d = state;
    rem_d   = remaining;
    mode_d  = mode_l;
    q_d     = q_r;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          q_d = bus.par_in;
        end else if (bus.start) begin
          if (bus.count != '0) begin
            state_d = ST_SHIFT;
            rem_d   = bus.count;
            mode_d  = bus.mode;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (bus.step) begin
          q_d = shift_q;
        end
      end
      ST_SHIFT: begin
        q_d   = shift_q;
        rem_d = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      mode_l    <= MODE_HOLD;
      q_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      mode_l    <= mode_d;
      q_r       <= q_d;
      busy_r    <= busy_d;
      done_r    <= done_d;
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.state  = state;

`ifdef SHREG_PARITY_EN
  logic par_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_r <= 1'b0;
    else        par_r <= ^q_d;
  end

  assign bus.par_out = par_r;
`endif

endmodule
